// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared types for the multi-lane register file: lane index
//                width and type for live-value-table entries, and the
//                clear-sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_pkg;

    // Widest supported lane count; LVT entries are sized for it so a single
    // lane_idx_t serves every legal LANES setting (1..4).
    localparam int MAX_LANES = 4;

    // $clog2 of the lane count, never below one bit.
    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int LANE_W = lane_w(MAX_LANES);

    typedef logic [LANE_W-1:0] lane_idx_t;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/multi_lane_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_lane_regfile_if
//  Description : Per-lane write and read buses of the multi-lane register
//                file, packed lane-major (lane i at [i*W +: W]).
//  Revision    : 1.0  initial release
// ============================================================================
interface multi_lane_regfile_if #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic                      ready;
    logic [LANES-1:0]          rd_we;
    logic [LANES*ADDR_W-1:0]   rd_addr;
    logic [LANES*DATA_W-1:0]   rd_data;
    logic [LANES*ADDR_W-1:0]   rs1_addr;
    logic [LANES*ADDR_W-1:0]   rs2_addr;
    logic [LANES*DATA_W-1:0]   rs1_data;
    logic [LANES*DATA_W-1:0]   rs2_data;

    // Issue/writeback side
    modport master (
        input  ready, rs1_data, rs2_data,
        output rd_we, rd_addr, rd_data, rs1_addr, rs2_addr
    );

    // Register file side
    modport slave (
        output ready, rs1_data, rs2_data,
        input  rd_we, rd_addr, rd_data, rs1_addr, rs2_addr
    );
endinterface
`default_nettype wire

// File: rtl/regfile_bank.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_bank
//  Description : One storage bank: a single write port, a clear-write port
//                that takes priority, and NRD asynchronous read ports.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_bank
    import rf_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int NRD    = 4
) (
    input  wire logic                    clk,
    input  wire logic                    we,
    input  wire logic [ADDR_W-1:0]       waddr,
    input  wire logic [DATA_W-1:0]       wdata,
    input  wire logic                    clr_we,
    input  wire logic [ADDR_W-1:0]       clr_addr,
    input  wire logic [NRD*ADDR_W-1:0]   raddr,
    output logic      [NRD*DATA_W-1:0]   rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next memory image: clear write wins over the lane write.
    always_comb begin
        mem_d = mem_q;
        if (clr_we) begin
            mem_d[clr_addr] = '0;
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage has no reset; the clear sequencer initialises what is observable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign rdata[k*DATA_W +: DATA_W] = mem_q[raddr[k*ADDR_W +: ADDR_W]];
    end
endmodule
`default_nettype wire

// File: rtl/multi_lane_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : multi_lane_regfile
//  Description : N-lane register file built from per-lane banks and a
//                live-value table. Owns write-conflict resolution (highest
//                lane wins), optional same-cycle bypass, x0 masking and the
//                post-reset clear sequencer that drives ready.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_lane_regfile
    import rf_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    multi_lane_regfile_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NRD   = 2 * LANES;   // read port k = 2*lane + (0:rs1, 1:rs2)

    rf_state_e               state_q, state_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic                    clr_we;
    logic                    ready;
    lane_idx_t               lvt_q [DEPTH];
    lane_idx_t               lvt_d [DEPTH];
    logic [LANES-1:0]        lane_we;
    logic [NRD*ADDR_W-1:0]   rd_addr_all;
    logic [NRD*DATA_W-1:0]   rd_data_all;
    logic [NRD*DATA_W-1:0]   bank_rdata [LANES];

    // Clear sequencer: walk every address once, then sit in RUN until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        if (state_q == CLEAR && !rst) begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready     = (state_q == RUN);
    assign bus.ready = ready;

    // A lane write counts only in RUN, outside a reset cycle, and not to x0.
    always_comb begin
        lane_we = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_we[i] = ready && !rst && bus.rd_we[i] &&
                         (bus.rd_addr[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    // LVT update: ascending lane order makes the highest lane win a conflict.
    always_comb begin
        lvt_d = lvt_q;
        if (clr_we) begin
            lvt_d[cnt_q] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
                lvt_d[bus.rd_addr[i*ADDR_W +: ADDR_W]] = lane_idx_t'(i);
            end
        end
    end

    // LVT storage, initialised by the clear sequencer rather than reset.
    always_ff @(posedge clk) begin
        lvt_q <= lvt_d;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_raddr
        assign rd_addr_all[(2*l)*ADDR_W   +: ADDR_W] = bus.rs1_addr[l*ADDR_W +: ADDR_W];
        assign rd_addr_all[(2*l+1)*ADDR_W +: ADDR_W] = bus.rs2_addr[l*ADDR_W +: ADDR_W];
    end

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        regfile_bank #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .NRD    (NRD)
        ) u_bank (
            .clk      (clk),
            .we       (lane_we[b]),
            .waddr    (bus.rd_addr[b*ADDR_W +: ADDR_W]),
            .wdata    (bus.rd_data[b*DATA_W +: DATA_W]),
            .clr_we   ((b == 0) ? clr_we : 1'b0),
            .clr_addr (cnt_q),
            .raddr    (rd_addr_all),
            .rdata    (bank_rdata[b])
        );
    end

    // Read path: LVT picks the bank, bypass overrides, x0 and !ready force zero.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] val;
        a           = '0;
        val         = '0;
        rd_data_all = '0;
        for (int k = 0; k < NRD; k++) begin
            a   = rd_addr_all[k*ADDR_W +: ADDR_W];
            val = bank_rdata[lvt_q[a]][k*DATA_W +: DATA_W];
            if (BYPASS != 0) begin
                for (int i = 0; i < LANES; i++) begin
                    if (lane_we[i] && (bus.rd_addr[i*ADDR_W +: ADDR_W] == a)) begin
                        val = bus.rd_data[i*DATA_W +: DATA_W];
                    end
                end
            end
            if (!ready || (a == '0)) begin
                val = '0;
            end
            rd_data_all[k*DATA_W +: DATA_W] = val;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_rout
        assign bus.rs1_data[l*DATA_W +: DATA_W] = rd_data_all[(2*l)*DATA_W   +: DATA_W];
        assign bus.rs2_data[l*DATA_W +: DATA_W] = rd_data_all[(2*l+1)*DATA_W +: DATA_W];
    end
endmodule
`default_nettype wire

// File: tb/tb_multi_lane_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_lane_regfile
//  Description : Directed self-checking bench for multi_lane_regfile
//                (LANES=2, ADDR_W=4, DATA_W=32, BYPASS=1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_lane_regfile;
    localparam int LANES = 2;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;

    always #50 clk = ~clk;

    multi_lane_regfile_if #(.LANES(LANES), .ADDR_W(AW), .DATA_W(DW)) bus ();

    multi_lane_regfile #(
        .LANES  (LANES),
        .ADDR_W (AW),
        .DATA_W (DW),
        .BYPASS (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [DEPTH];
    logic        pw_we   [LANES];
    logic [3:0]  pw_addr [LANES];
    logic [31:0] pw_data [LANES];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] got);
        logic [31:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: got %h, expected value missing from scoreboard", tag, got);
        end else begin
            e = exp_q.pop_front();
            assert (got === e) else begin
                n_fail++;
                $error("FAIL %s: got %h, expected %h", tag, got, e);
            end
        end
    endtask

    function automatic logic [31:0] rd_port(input int lane, input int which);
        return (which == 0) ? bus.rs1_data[lane*DW +: DW] : bus.rs2_data[lane*DW +: DW];
    endfunction

    task automatic rd_chk(input string tag, input int lane, input int which,
                          input logic [3:0] addr, input logic [31:0] e);
        if (which == 0) bus.rs1_addr[lane*AW +: AW] = addr;
        else            bus.rs2_addr[lane*AW +: AW] = addr;
        sb_push(e);
        #1;
        sb_check(tag, rd_port(lane, which));
    endtask

    task automatic rd_all4(input string tag, input logic [3:0] addr, input logic [31:0] e);
        for (int l = 0; l < LANES; l++) begin
            for (int w = 0; w < 2; w++) begin
                rd_chk(tag, l, w, addr, e);
            end
        end
    endtask

    task automatic set_wr(input int lane, input logic [3:0] addr, input logic [31:0] data);
        bus.rd_we[lane]              = 1'b1;
        bus.rd_addr[lane*AW +: AW]   = addr;
        bus.rd_data[lane*DW +: DW]   = data;
        pw_we[lane]   = 1'b1;
        pw_addr[lane] = addr;
        pw_data[lane] = data;
    endtask

    task automatic clr_wr();
        bus.rd_we = '0;
        for (int l = 0; l < LANES; l++) pw_we[l] = 1'b0;
    endtask

    // Apply pending writes to the model (lane order = program order), clock them in.
    task automatic commit();
        for (int l = 0; l < LANES; l++) begin
            if (pw_we[l] && pw_addr[l] != 4'd0) model[pw_addr[l]] = pw_data[l];
        end
        tick();
        clr_wr();
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) model[a] = 32'h0;
    endtask

    // Count cycles with ready low; pending writes are dropped once ready is seen.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 40) begin
            n++;
            tick();
        end
        clr_wr();
        sb_push(32'd16);
        sb_check(tag, 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.rd_we    = '0;
        bus.rd_addr  = '0;
        bus.rd_data  = '0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        clr_wr();
        model_clear();

        // Reset held three cycles
        tick(); tick(); tick();
        sb_push(32'd0);
        sb_check("rst_ready", 32'(bus.ready));
        rd_chk("rst_read", 0, 0, 4'd5, 32'h0);

        // Clear sequence length and cleared contents
        rst = 1'b0;
        wait_ready("clear_latency");
        sb_push(32'd1);
        sb_check("ready_high", 32'(bus.ready));
        for (int a = 1; a < DEPTH; a++) begin
            rd_chk("clear_read", a % 2, (a / 2) % 2, 4'(a), model[a]);
        end
        tick();

        // Cross-lane visibility with same-cycle bypass
        set_wr(0, 4'd5, 32'hDEADBEEF);
        rd_chk("bypass_xlane", 1, 1, 4'd5, 32'hDEADBEEF);
        commit();
        rd_chk("xlane_next", 1, 1, 4'd5, model[5]);
        rd_chk("xlane_own", 0, 0, 4'd5, 32'hDEADBEEF);

        // Same-address conflict: lane1 wins, then lane0 alone retakes it
        set_wr(0, 4'd3, 32'h11);
        set_wr(1, 4'd3, 32'h22);
        rd_chk("bypass_conflict", 0, 0, 4'd3, 32'h22);
        commit();
        rd_all4("conflict_stored", 4'd3, 32'h22);
        tick();
        set_wr(0, 4'd3, 32'h33);
        commit();
        rd_all4("lane0_rewrite", 4'd3, 32'h33);
        tick();

        // x0 writes are dropped and leave other state alone
        set_wr(1, 4'd0, 32'hFFFFFFFF);
        rd_chk("x0_bypass", 1, 0, 4'd0, 32'h0);
        commit();
        rd_all4("x0_read", 4'd0, 32'h0);
        rd_chk("x0_no_side", 1, 1, 4'd3, model[3]);
        tick();

        // Fill r1..r15, odd addresses from lane1; a dual-lane cycle at the end
        for (int a = 1; a < DEPTH - 2; a++) begin
            set_wr(a % 2, 4'(a), 32'hA5000000 | (32'(a) << 8) | 32'(a));
            commit();
        end
        set_wr(0, 4'd14, 32'hC0DE000E);
        set_wr(1, 4'd15, 32'hC0DE000F);
        commit();
        for (int a = 1; a < DEPTH; a++) begin
            rd_chk("fill_l0", 0, 0, 4'(a), model[a]);
            rd_chk("fill_l1", 1, 1, 4'(a), model[a]);
        end
        tick();

        // Mid-run reset pulse with a write in the reset cycle
        rst = 1'b1;
        set_wr(1, 4'd9, 32'h77);
        tick();
        rst = 1'b0;
        clr_wr();
        model_clear();
        sb_push(32'd0);
        sb_check("midrst_ready", 32'(bus.ready));
        rd_chk("midrst_read", 1, 0, 4'd9, 32'h0);

        // Writes held during the clear are discarded
        set_wr(0, 4'd7, 32'h55);
        wait_ready("midrst_latency");
        for (int a = 1; a < DEPTH; a++) begin
            rd_chk("post_clear_l0", 0, 1, 4'(a), model[a]);
            rd_chk("post_clear_l1", 1, 0, 4'(a), model[a]);
        end
        tick();
        rd_all4("r7_dropped", 4'd7, 32'h0);
        tick();

        // Normal operation resumes after the clear
        set_wr(1, 4'd7, 32'h12345678);
        commit();
        rd_chk("resume_l0", 0, 0, 4'd7, model[7]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
